// File: rtl/nz_group_scheduler.sv
// Non-zero group scheduler: walks a latched non-zero bitmap and presents up to
// MAC_DIM ascending scratchpad addresses per cycle to a sparse MAC PE.
module nz_group_scheduler #(
  parameter int unsigned MAC_DIM    = 6,
  parameter int unsigned SPAD_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [SPAD_WIDTH-1:0]         nz_mask,
  input  logic                          stall,
  output logic                          busy,
  output logic                          grp_vld,
  output logic [ADDR_WIDTH*MAC_DIM-1:0] non_zero_add_out,
  output logic [NUM_WIDTH-1:0]          non_zero_num,
  output logic                          acc,
  output logic                          done
);

  typedef enum logic {StIdle, StRun} state_t;

  // StRun means a group is currently presented on the outputs.
  state_t                          r_state, w_state_d;
  logic [SPAD_WIDTH-1:0]           r_rem, w_rem_d;
  logic                            r_grp_vld, w_grp_vld_d;
  logic [ADDR_WIDTH*MAC_DIM-1:0]   r_addr, w_addr_d;
  logic [NUM_WIDTH-1:0]            r_num, w_num_d;
  logic                            r_acc, w_acc_d;
  logic                            r_done, w_done_d;

  logic [ADDR_WIDTH*MAC_DIM-1:0]   w_sel_addr;
  logic [NUM_WIDTH-1:0]            w_sel_num;
  logic [SPAD_WIDTH-1:0]           w_sel_rem;
  logic                            w_sel_last;

  // Cascaded find-first-set: each stage takes the lowest set bit and clears it.
  // In idle the scan runs on the incoming mask so the first group is ready at start.
  always_comb begin
    logic [SPAD_WIDTH-1:0] w_scan;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_hit;
    w_scan     = (r_state == StIdle) ? nz_mask : r_rem;
    w_sel_addr = '0;
    w_sel_num  = '0;
    for (int j = 0; j < MAC_DIM; j++) begin
      w_hit = 1'b0;
      w_idx = '0;
      for (int i = SPAD_WIDTH - 1; i >= 0; i--) begin
        if (w_scan[i]) begin
          w_hit = 1'b1;
          w_idx = ADDR_WIDTH'(i);
        end
      end
      if (w_hit) begin
        w_sel_addr[j*ADDR_WIDTH +: ADDR_WIDTH] = w_idx;
        w_sel_num                              = NUM_WIDTH'(j);
        w_scan[w_idx]                          = 1'b0;
      end
    end
    w_sel_rem  = w_scan;
    w_sel_last = ~|w_scan;
  end

  // Next-state and next-group logic; stall freezes everything while a group is shown.
  always_comb begin
    w_state_d   = r_state;
    w_rem_d     = r_rem;
    w_grp_vld_d = r_grp_vld;
    w_addr_d    = r_addr;
    w_num_d     = r_num;
    w_acc_d     = r_acc;
    w_done_d    = r_done;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d   = StRun;
          w_rem_d     = w_sel_rem;
          w_grp_vld_d = 1'b1;
          w_addr_d    = w_sel_addr;
          w_num_d     = w_sel_num;
          w_acc_d     = 1'b0;
          w_done_d    = w_sel_last;
        end
      end
      StRun: begin
        if (!stall) begin
          if (r_done) begin
            // Last group consumed; start is ignored here to force an idle cycle.
            w_state_d   = StIdle;
            w_rem_d     = '0;
            w_grp_vld_d = 1'b0;
            w_addr_d    = '0;
            w_num_d     = '0;
            w_acc_d     = 1'b0;
            w_done_d    = 1'b0;
          end else begin
            w_rem_d     = w_sel_rem;
            w_grp_vld_d = 1'b1;
            w_addr_d    = w_sel_addr;
            w_num_d     = w_sel_num;
            w_acc_d     = 1'b1;
            w_done_d    = w_sel_last;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_rem     <= '0;
      r_grp_vld <= 1'b0;
      r_addr    <= '0;
      r_num     <= '0;
      r_acc     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rem     <= w_rem_d;
      r_grp_vld <= w_grp_vld_d;
      r_addr    <= w_addr_d;
      r_num     <= w_num_d;
      r_acc     <= w_acc_d;
      r_done    <= w_done_d;
    end
  end

  assign busy             = (r_state == StRun);
  assign grp_vld          = r_grp_vld;
  assign non_zero_add_out = r_addr;
  assign non_zero_num     = r_num;
  assign acc              = r_acc;
  assign done             = r_done;

endmodule

// File: tb/tb_nz_group_scheduler.sv
// Directed bench for nz_group_scheduler with hand-computed expected groups.
module tb_nz_group_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] nz_mask;
  logic        stall;
  logic        busy;
  logic        grp_vld;
  logic [35:0] non_zero_add_out;
  logic [2:0]  non_zero_num;
  logic        acc;
  logic        done;

  int n_cmp;
  int n_fail;

  nz_group_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .nz_mask          (nz_mask),
    .stall            (stall),
    .busy             (busy),
    .grp_vld          (grp_vld),
    .non_zero_add_out (non_zero_add_out),
    .non_zero_num     (non_zero_num),
    .acc              (acc),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] lanes(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5);
    lanes = {6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  // Full output compare: {busy, grp_vld, lanes, num, acc, done}.
  task automatic check_grp(input string tag, input logic e_busy, input logic e_vld,
                           input logic [35:0] e_lanes, input int e_num,
                           input logic e_acc, input logic e_done);
    logic [42:0] obs;
    logic [42:0] exp;
    obs = {busy, grp_vld, non_zero_add_out, non_zero_num, acc, done};
    exp = {e_busy, e_vld, e_lanes, 3'(e_num), e_acc, e_done};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control-only compare for cycles with no group.
  task automatic check_idle(input string tag);
    logic [3:0] obs;
    obs = {busy, grp_vld, acc, done};
    n_cmp++;
    assert (obs === 4'b0000) else begin
      n_fail++;
      $error("FAIL %s: observed busy/vld/acc/done %b expected 0000", tag, obs);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    nz_mask = '0;
    tick();
    tick();
    check_grp("reset_state", 0, 0, 36'd0, 0, 0, 0);
    reset = 1'b1;
    tick();
    check_grp("idle_after_reset", 0, 0, 36'd0, 0, 0, 0);

    // Single group {2,5,9}
    nz_mask = (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 9);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check_grp("t1_grp", 1, 1, lanes(2, 5, 9, 0, 0, 0), 2, 0, 1);
    tick();
    check_idle("t1_idle");

    // Bits 0..12: three groups
    nz_mask = 64'h1FFF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check_grp("t2_g1", 1, 1, lanes(0, 1, 2, 3, 4, 5), 5, 0, 0);
    tick();
    check_grp("t2_g2", 1, 1, lanes(6, 7, 8, 9, 10, 11), 5, 1, 0);
    tick();
    check_grp("t2_g3", 1, 1, lanes(12, 0, 0, 0, 0, 0), 0, 1, 1);
    tick();
    check_idle("t2_idle");

    // Empty vector, with stall held in idle (must not block the start)
    nz_mask = '0;
    start   = 1'b1;
    stall   = 1'b1;
    tick();
    start   = 1'b0;
    stall   = 1'b0;
    check_grp("t3_empty", 1, 1, 36'd0, 0, 0, 1);
    tick();
    check_idle("t3_idle");

    // Six scattered bits, stalled for three cycles after the group appears
    nz_mask = (64'd1 << 63) | (64'd1 << 40) | (64'd1 << 1) | (64'd1 << 7) |
              (64'd1 << 20) | (64'd1 << 33);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check_grp("t4_grp", 1, 1, lanes(1, 7, 20, 33, 40, 63), 5, 0, 1);
    stall   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_grp($sformatf("t4_hold%0d", c), 1, 1, lanes(1, 7, 20, 33, 40, 63), 5, 0, 1);
    end
    stall = 1'b0;
    tick();
    check_idle("t4_idle");

    // Start pulsed during second group and coincident with the done group
    nz_mask = 64'h1FFF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check_grp("t5_g1", 1, 1, lanes(0, 1, 2, 3, 4, 5), 5, 0, 0);
    nz_mask = 64'hFFFF_0000_0000_0000;
    tick();
    check_grp("t5_g2", 1, 1, lanes(6, 7, 8, 9, 10, 11), 5, 1, 0);
    start = 1'b1;
    tick();
    check_grp("t5_g3", 1, 1, lanes(12, 0, 0, 0, 0, 0), 0, 1, 1);
    tick();
    start = 1'b0;
    check_idle("t5_idle");
    tick();
    check_idle("t5_idle2");

    // Asynchronous reset during the second group
    nz_mask = 64'h1FFF;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    check_grp("t6_g2", 1, 1, lanes(6, 7, 8, 9, 10, 11), 5, 1, 0);
    #1;
    reset = 1'b0;
    #1;
    check_grp("t6_async_rst", 0, 0, 36'd0, 0, 0, 0);
    #1;
    reset = 1'b1;
    tick();
    check_grp("t6_post_rst1", 0, 0, 36'd0, 0, 0, 0);
    tick();
    check_grp("t6_post_rst2", 0, 0, 36'd0, 0, 0, 0);

    // Recovery with a fresh start
    nz_mask = (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 9);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check_grp("t7_grp", 1, 1, lanes(2, 5, 9, 0, 0, 0), 2, 0, 1);
    tick();
    check_idle("t7_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nz_group_scheduler.md
Name: nz_group_scheduler

Overview:
- Feeds one 6-lane sparse MAC processing element.
- Takes a SPAD_WIDTH-bit non-zero bitmap for the feature vector currently held in the feature/weight scratchpads.
- Each cycle it emits one group of up to MAC_DIM non-zero scratchpad addresses, packed in the PE's address-lane format, with the PE's non_zero_num, acc and done controls.
- Sits between the feature-load controller and the PE.

Parameters:
- MAC_DIM, 6, address lanes per group; the PE multiplier count.
- SPAD_WIDTH, 64, scratchpad entries; also the bitmap width.
- ADDR_WIDTH, 6, scratchpad index width; equals log2(SPAD_WIDTH).
- NUM_WIDTH, 3, width of the non_zero_num field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; latch nz_mask and begin a scan.
- nz_mask  input  SPAD_WIDTH  bit i = 1 means scratchpad entry i is non-zero.
- stall  input  1  PE back-pressure; freezes all state and outputs.
- busy  output  1  scan in progress.
- grp_vld  output  1  current group outputs are valid.
- non_zero_add_out  output  ADDR_WIDTH*MAC_DIM  lane j address in bits [(j+1)*ADDR_WIDTH-1 : j*ADDR_WIDTH].
- non_zero_num  output  NUM_WIDTH  number of valid lanes minus 1 (0 means lane 0 only; 5 means all six).
- acc  output  1  0 on the first group of a vector (MAC clears), 1 on later groups.
- done  output  1  high with the last group of a vector.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - Internal mask register clears.
  - busy, grp_vld, acc and done go to 0.
  - non_zero_add_out and non_zero_num go to 0.
  - Reset asserted mid-scan aborts the scan; no partial done is produced.
- FSM: IDLE, RUN.
  - IDLE: on start = 1, latch rem <= nz_mask, set first <= 1, go to RUN. busy goes to 1 in the next cycle.
  - RUN, stall = 0: each cycle register one group.
    - Select the lowest-indexed set bits of rem, up to MAC_DIM of them, in ascending order into lanes 0..k-1.
    - Clear the selected bits from rem.
    - non_zero_num <= k-1, acc <= ~first, first <= 0, grp_vld <= 1.
    - done <= 1 if rem has no set bits left after clearing; then return to IDLE.
  - Empty vector (popcount = 0): emit exactly one group with lane 0 address 0, non_zero_num = 0, acc = 0, done = 1. The PE then produces a zero sum.
  - Unused lanes (index >= k) are driven to address 0.
  - grp_vld, acc and done are 0 in any cycle with no group.
- Latency:
  - First group is valid the cycle after the start cycle.
  - A vector with popcount P produces max(1, ceil(P/6)) consecutive groups when not stalled.
  - done is on the final group only.
  - busy stays high from the cycle after start through the cycle done is high; it drops the following cycle.
- stall = 1:
  - All registers hold, including the outputs of the current group.
  - The group is consumed in the first cycle with stall = 0.
  - stall in IDLE has no effect.
- start while busy: ignored; nz_mask is not re-latched.
- start coincident with the done group: ignored. Back-to-back start is accepted only in IDLE, so there is at least one idle cycle between vectors.
- Selection is combinational priority logic over rem: six cascaded find-first-set stages, each masking the previous winner. This logic must close timing in one cycle at SPAD_WIDTH = 64.

Test Plan:
- Mask bits {2,5,9}, start -> one cycle later: lanes = 2,5,9,0,0,0; non_zero_num = 2; acc = 0; done = 1; grp_vld = 1. busy drops the cycle after.
- Mask bits 0..12 -> three groups:
  - lanes 0-5, num 5, acc 0, done 0;
  - lanes 6-11, num 5, acc 1, done 0;
  - lane 12, num 0, acc 1, done 1.
- Mask = 0 -> a single group: lane 0 = 0, num = 0, acc = 0, done = 1.
- Mask bits {63,40,1,7,20,33}, with stall = 1 for 3 cycles after the group appears -> lanes 1,7,20,33,40,63 held stable for 4 cycles; num = 5; done = 1 asserted exactly once (held); busy drops after stall releases.
- Mask bits 0..12, start pulsed again during the second group -> the output sequence is identical to the no-pulse case.
- Mask bits 0..12, reset low during the second group -> all outputs 0 immediately (asynchronous). After reset releases, the block stays IDLE with no further groups until a new start.
